sram_like_arbiter: RTL and testbench
====================================

SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, giving the consecutive data grants allowed while inst_req is pending (legal range 1..15).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port inst_req  input  1  instruction fetch request, held until inst_addr_ok.
REQ-005 SHALL have port inst_addr  input  32  fetch address.
REQ-006 SHALL have port inst_addr_ok  output  1  fetch request accepted.
REQ-007 SHALL have port inst_data_ok  output  1  fetch data valid on rdata.
REQ-008 SHALL have port data_req  input  1  data request, held until data_addr_ok.
REQ-009 SHALL have port data_wr  input  1  1 = write, 0 = read.
REQ-010 SHALL have port data_size  input  2  0 = byte, 1 = half, 2 = word.
REQ-011 SHALL have port data_addr  input  32  data address.
REQ-012 SHALL have port data_wdata  input  32  write data.
REQ-013 SHALL have port data_addr_ok  output  1  data request accepted.
REQ-014 SHALL have port data_data_ok  output  1  data read/write complete.
REQ-015 SHALL have port rdata  output  32  read data shared by both requesters, qualified by the matching *_data_ok.
REQ-016 SHALL have port m_req  output  1  request toward the AXI bridge SRAM-like port.
REQ-017 SHALL have port m_wr, m_size, m_addr, m_wdata  output  1/2/32/32  muxed request fields.
REQ-018 SHALL have port m_addr_ok  input  1  bridge accepted m_req.
REQ-019 SHALL have port m_data_ok  input  1  bridge completed the transaction.
REQ-020 SHALL have port m_rdata  input  32  bridge read data.

Function
REQ-021 SHALL implement an FSM with states IDLE, ADDR and DATA, and a registered owner (INST/DATA); at most one transaction SHALL be outstanding.
REQ-022 Arbitration SHALL occur in IDLE, and in DATA on the cycle m_data_ok=1.
- If any req is high at that point, the FSM SHALL go to ADDR with the new owner registered.
- Otherwise the FSM SHALL go to (or stay in) IDLE.
REQ-023 Priority SHALL be data over inst, except that inst SHALL win when starve_cnt == STARVE_LIMIT and inst_req=1.
REQ-024 starve_cnt (4-bit) SHALL behave as follows:
- increments on each data grant made while inst_req=1;
- clears on every inst grant;
- saturates at STARVE_LIMIT.
REQ-025 In ADDR, the m_* outputs SHALL combinationally follow the owner's inputs:
- m_req equals the owner's req;
- for owner INST: m_wr=0, m_size=2, m_wdata=0, m_addr=inst_addr.
REQ-026 In IDLE and DATA, m_req SHALL be 0; m_wr/m_size/m_addr/m_wdata SHALL hold the last driven values.
REQ-027 The owner's *_addr_ok SHALL equal m_addr_ok only in ADDR; the non-owner's *_addr_ok SHALL be 0.
REQ-028 ADDR SHALL go to DATA on m_addr_ok=1.
REQ-029 If the owner drops req in ADDR (protocol violation), the FSM SHALL stay in ADDR with m_req=0 and SHALL NOT switch owner.
REQ-030 In DATA, the owner's *_data_ok SHALL equal m_data_ok and rdata SHALL equal m_rdata (combinational); m_data_ok SHALL be ignored outside DATA.
REQ-031 Latency: a request arriving in IDLE SHALL reach m_req 1 cycle later; a back-to-back request SHALL reach m_req on the cycle after m_data_ok with no IDLE bubble.

Reset
REQ-032 When rst=1 at a clock edge, the block SHALL set state=IDLE, owner=DATA, starve_cnt=0 and all outputs to 0; any outstanding transaction SHALL be abandoned, and m_data_ok arriving after reset SHALL be ignored.

Verification
REQ-033 Single fetch: inst_req=1 with addr 0xBFC00000 from IDLE -> m_req=1 next cycle with m_addr=0xBFC00000, m_size=2, m_wr=0; m_addr_ok -> inst_addr_ok=1; m_data_ok with m_rdata=0x3C1DBFC0 -> inst_data_ok=1 and rdata=0x3C1DBFC0.
REQ-034 Simultaneous requests: inst_req and data_req (store, size 0, addr 0x80000004, wdata 0xAB) in the same cycle -> data granted first (m_wr=1, m_size=0); inst granted on the data_ok cycle, and m_req=1 with inst_addr on the following cycle.
REQ-035 Starvation: data_req held continuously with inst_req=1 and STARVE_LIMIT=4 -> grants follow D,D,D,D,I,D,D,D,D,I; starve_cnt returns to 0 after each inst grant.
REQ-036 Backpressure: m_addr_ok held 0 for 5 cycles -> m_req stays 1, the owner is unchanged, and the non-owner addr_ok stays 0 throughout.
REQ-037 Reset mid-operation: rst pulsed while in DATA -> all outputs 0 next cycle; a later m_data_ok produces no *_data_ok; the next request is arbitrated normally.

Source files
------------

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter
//   Arbitrates two SRAM-like masters (instruction fetch and data) onto one
//   SRAM-like port toward an AXI bridge. At most one transaction is outstanding.
//   Data requests win over instruction fetches, except that a fetch is forced
//   through once STARVE_LIMIT consecutive data grants have been made while it
//   was waiting.
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   inst_req/inst_addr        fetch request in; inst_addr_ok/inst_data_ok out
//   data_req/wr/size/addr/wdata  data request in; data_addr_ok/data_data_ok out
//   rdata                     read data, qualified by the owner's *_data_ok
//   m_req/wr/size/addr/wdata  muxed request toward the bridge
//   m_addr_ok/m_data_ok/m_rdata  bridge handshake and read data
module sram_like_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_e;
  typedef enum logic {OWN_DATA = 1'b0, OWN_INST = 1'b1} owner_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic [3:0]  starve_q, starve_d;

  // Last values driven on the m_* request fields, shown while not in ADDR.
  logic        hold_wr_q;
  logic [1:0]  hold_size_q;
  logic [31:0] hold_addr_q;
  logic [31:0] hold_wdata_q;

  logic owner_req;
  logic arb_en;
  logic inst_wins;

  assign owner_req = (owner_q == OWN_INST) ? inst_req : data_req;
  assign arb_en    = (state_q == S_IDLE) || ((state_q == S_DATA) && m_data_ok);
  assign inst_wins = inst_req && (!data_req || (starve_q == LIMIT));

  // Next-state: arbitration happens in IDLE and on the completing DATA cycle,
  // so a back-to-back request goes straight to ADDR without an IDLE bubble.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    if (arb_en) begin
      if (inst_req || data_req) begin
        state_d = S_ADDR;
        if (inst_wins) begin
          owner_d  = OWN_INST;
          starve_d = '0;
        end else begin
          owner_d = OWN_DATA;
          if (inst_req && (starve_q != LIMIT)) begin
            starve_d = starve_q + 4'd1;
          end
        end
      end else begin
        state_d = S_IDLE;
      end
    end else if (state_q == S_ADDR) begin
      // An owner that drops its request keeps ownership; nothing is accepted.
      if (m_addr_ok && owner_req) begin
        state_d = S_DATA;
      end
    end
  end

  always_comb begin
    m_req        = 1'b0;
    m_wr         = hold_wr_q;
    m_size       = hold_size_q;
    m_addr       = hold_addr_q;
    m_wdata      = hold_wdata_q;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    rdata        = '0;
    case (state_q)
      S_ADDR: begin
        m_req = owner_req;
        if (owner_q == OWN_INST) begin
          m_wr         = 1'b0;
          m_size       = 2'd2;
          m_addr       = inst_addr;
          m_wdata      = '0;
          inst_addr_ok = m_addr_ok;
        end else begin
          m_wr         = data_wr;
          m_size       = data_size;
          m_addr       = data_addr;
          m_wdata      = data_wdata;
          data_addr_ok = m_addr_ok;
        end
      end
      S_DATA: begin
        rdata = m_rdata;
        if (owner_q == OWN_INST) begin
          inst_data_ok = m_data_ok;
        end else begin
          data_data_ok = m_data_ok;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_DATA;
      starve_q     <= '0;
      hold_wr_q    <= 1'b0;
      hold_size_q  <= '0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      if (state_q == S_ADDR) begin
        hold_wr_q    <= m_wr;
        hold_size_q  <= m_size;
        hold_addr_q  <= m_addr;
        hold_wdata_q <= m_wdata;
      end
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_addr_ok, inst_data_ok;
  logic        data_req = 1'b0;
  logic        data_wr = 1'b0;
  logic [1:0]  data_size = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] rdata;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata;
  logic        m_addr_ok = 1'b0;
  logic        m_data_ok = 1'b0;
  logic [31:0] m_rdata = '0;

  sram_like_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .rdata(rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwr;
    logic [1:0]  dsz;
    logic [31:0] daddr;
    logic [31:0] dwd;
    logic        aok;
    logic        dok;
    logic [31:0] rd;
  } in_t;

  typedef struct packed {
    logic        mreq;
    logic        mwr;
    logic [1:0]  msz;
    logic [31:0] maddr;
    logic [31:0] mwd;
    logic        iaok;
    logic        idok;
    logic        daok;
    logic        ddok;
    logic [31:0] rdata;
  } out_t;

  typedef struct {
    in_t  in;
    logic chk;
    out_t exp;
  } vec_t;

  vec_t vecs[15];
  int   n_cmp = 0;
  int   n_fail = 0;

  function automatic in_t mk_in(logic r, logic ireq, logic [31:0] iaddr, logic dreq,
                                logic dwr, logic [1:0] dsz, logic [31:0] daddr,
                                logic [31:0] dwd, logic aok, logic dok, logic [31:0] rd);
    in_t v;
    v.rst = r; v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.dwr = dwr;
    v.dsz = dsz; v.daddr = daddr; v.dwd = dwd; v.aok = aok; v.dok = dok; v.rd = rd;
    return v;
  endfunction

  function automatic out_t mk_out(logic mreq, logic mwr, logic [1:0] msz,
                                  logic [31:0] maddr, logic [31:0] mwd, logic iaok,
                                  logic idok, logic daok, logic ddok, logic [31:0] rd);
    out_t o;
    o.mreq = mreq; o.mwr = mwr; o.msz = msz; o.maddr = maddr; o.mwd = mwd;
    o.iaok = iaok; o.idok = idok; o.daok = daok; o.ddok = ddok; o.rdata = rd;
    return o;
  endfunction

  // Drive one cycle of inputs after the falling edge; outputs settle before
  // the next rising edge and are checked in between.
  task automatic step(input in_t v);
    @(negedge clk);
    rst = v.rst; inst_req = v.ireq; inst_addr = v.iaddr;
    data_req = v.dreq; data_wr = v.dwr; data_size = v.dsz;
    data_addr = v.daddr; data_wdata = v.dwd;
    m_addr_ok = v.aok; m_data_ok = v.dok; m_rdata = v.rd;
    #2;
  endtask

  task automatic check_out(input string name, input out_t exp);
    out_t got;
    got = {m_req, m_wr, m_size, m_addr, m_wdata,
           inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, rdata};
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got req=%b wr=%b sz=%0d addr=%h wd=%h iaok=%b idok=%b daok=%b ddok=%b rdata=%h | required req=%b wr=%b sz=%0d addr=%h wd=%h iaok=%b idok=%b daok=%b ddok=%b rdata=%h",
               name, got.mreq, got.mwr, got.msz, got.maddr, got.mwd, got.iaok, got.idok,
               got.daok, got.ddok, got.rdata, exp.mreq, exp.mwr, exp.msz, exp.maddr,
               exp.mwd, exp.iaok, exp.idok, exp.daok, exp.ddok, exp.rdata);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  initial begin
    in_t  v;
    logic exp_inst[10];

    // Single fetch, then data and fetch requested together.
    vecs[0]  = '{mk_in(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0), 1'b0, '0};
    vecs[1]  = '{mk_in(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0), 1'b1,
                 mk_out(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0)};
    vecs[2]  = '{mk_in(0, 1, 32'hBFC00000, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0), 1'b1,
                 mk_out(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0)};
    vecs[3]  = '{mk_in(0, 1, 32'hBFC00000, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0), 1'b1,
                 mk_out(1, 0, 2, 32'hBFC00000, 32'h0, 0, 0, 0, 0, 32'h0)};
    vecs[4]  = '{mk_in(0, 1, 32'hBFC00000, 0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h0), 1'b1,
                 mk_out(1, 0, 2, 32'hBFC00000, 32'h0, 1, 0, 0, 0, 32'h0)};
    vecs[5]  = '{mk_in(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0), 1'b1,
                 mk_out(0, 0, 2, 32'hBFC00000, 32'h0, 0, 0, 0, 0, 32'h0)};
    vecs[6]  = '{mk_in(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 32'h3C1DBFC0), 1'b1,
                 mk_out(0, 0, 2, 32'hBFC00000, 32'h0, 0, 1, 0, 0, 32'h3C1DBFC0)};
    vecs[7]  = '{mk_in(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 32'h55), 1'b1,
                 mk_out(0, 0, 2, 32'hBFC00000, 32'h0, 0, 0, 0, 0, 32'h0)};
    vecs[8]  = '{mk_in(0, 1, 32'hBFC00010, 1, 1, 0, 32'h80000004, 32'hAB, 0, 0, 32'h0), 1'b1,
                 mk_out(0, 0, 2, 32'hBFC00000, 32'h0, 0, 0, 0, 0, 32'h0)};
    vecs[9]  = '{mk_in(0, 1, 32'hBFC00010, 1, 1, 0, 32'h80000004, 32'hAB, 0, 0, 32'h0), 1'b1,
                 mk_out(1, 1, 0, 32'h80000004, 32'hAB, 0, 0, 0, 0, 32'h0)};
    vecs[10] = '{mk_in(0, 1, 32'hBFC00010, 1, 1, 0, 32'h80000004, 32'hAB, 1, 0, 32'h0), 1'b1,
                 mk_out(1, 1, 0, 32'h80000004, 32'hAB, 0, 0, 1, 0, 32'h0)};
    vecs[11] = '{mk_in(0, 1, 32'hBFC00010, 0, 1, 0, 32'h80000004, 32'hAB, 0, 1, 32'hCAFEF00D), 1'b1,
                 mk_out(0, 1, 0, 32'h80000004, 32'hAB, 0, 0, 0, 1, 32'hCAFEF00D)};
    vecs[12] = '{mk_in(0, 1, 32'hBFC00010, 0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h0), 1'b1,
                 mk_out(1, 0, 2, 32'hBFC00010, 32'h0, 1, 0, 0, 0, 32'h0)};
    vecs[13] = '{mk_in(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 32'h12345678), 1'b1,
                 mk_out(0, 0, 2, 32'hBFC00010, 32'h0, 0, 1, 0, 0, 32'h12345678)};
    vecs[14] = '{mk_in(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0), 1'b1,
                 mk_out(0, 0, 2, 32'hBFC00010, 32'h0, 0, 0, 0, 0, 32'h0)};

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].in);
      if (vecs[i].chk) check_out($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Backpressure: data owns the port for 5 stalled cycles while a fetch waits.
    v = mk_in(0, 1, 32'hBFC00020, 1, 0, 1, 32'h00001002, 32'h0, 0, 0, 32'h0);
    step(v);
    for (int i = 0; i < 5; i++) begin
      v.iaddr = 32'hBFC00020 + 32'(i * 4);
      step(v);
      check_out($sformatf("bp_stall%0d", i), mk_out(1, 0, 1, 32'h00001002, 32'h0, 0, 0, 0, 0, 32'h0));
    end
    v.dreq = 1'b0;
    step(v);
    check_out("bp_owner_drop", mk_out(0, 0, 1, 32'h00001002, 32'h0, 0, 0, 0, 0, 32'h0));
    v.dreq = 1'b1;
    step(v);
    check_out("bp_owner_kept", mk_out(1, 0, 1, 32'h00001002, 32'h0, 0, 0, 0, 0, 32'h0));
    v.aok = 1'b1;
    step(v);
    check_out("bp_accept", mk_out(1, 0, 1, 32'h00001002, 32'h0, 0, 0, 1, 0, 32'h0));
    v = mk_in(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 32'hA5A5A5A5);
    step(v);
    check_out("bp_done", mk_out(0, 0, 1, 32'h00001002, 32'h0, 0, 0, 0, 1, 32'hA5A5A5A5));

    // Reset while a write is in its data phase.
    v = mk_in(0, 0, 32'h0, 1, 1, 2, 32'h80001000, 32'hDEADBEEF, 0, 0, 32'h0);
    step(v);
    v.aok = 1'b1;
    step(v);
    check_out("rst_pre_accept", mk_out(1, 1, 2, 32'h80001000, 32'hDEADBEEF, 0, 0, 1, 0, 32'h0));
    v.dreq = 1'b0; v.aok = 1'b0; v.rst = 1'b1;
    step(v);
    check_out("rst_in_data", mk_out(0, 1, 2, 32'h80001000, 32'hDEADBEEF, 0, 0, 0, 0, 32'h0));
    v.rst = 1'b0; v.dok = 1'b1; v.rd = 32'h77777777;
    step(v);
    check_out("rst_outputs_zero", '0);
    step(v);
    check_out("rst_late_data_ok", '0);
    v = mk_in(0, 1, 32'hBFC00100, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    step(v);
    check_out("rst_next_idle", '0);
    step(v);
    check_out("rst_next_addr", mk_out(1, 0, 2, 32'hBFC00100, 32'h0, 0, 0, 0, 0, 32'h0));
    v.aok = 1'b1;
    step(v);
    check_out("rst_next_accept", mk_out(1, 0, 2, 32'hBFC00100, 32'h0, 1, 0, 0, 0, 32'h0));
    v = mk_in(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 32'h00001234);
    step(v);
    check_out("rst_next_data", mk_out(0, 0, 2, 32'hBFC00100, 32'h0, 0, 1, 0, 0, 32'h00001234));

    // Starvation: both requests held; fetch forced through after 4 data grants.
    exp_inst = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    v = mk_in(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    step(v);
    v = mk_in(0, 1, 32'hBFC00200, 1, 1, 2, 32'h80002000, 32'h0, 0, 0, 32'h0);
    step(v);
    for (int g = 0; g < 10; g++) begin
      v.aok = 1'b1; v.dok = 1'b0;
      step(v);
      check_val($sformatf("starve_grant%0d", g), {30'd0, inst_addr_ok, data_addr_ok},
                exp_inst[g] ? 32'd2 : 32'd1);
      v.aok = 1'b0; v.dok = 1'b1;
      step(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
